text_msg_scheduler: RTL and testbench
=====================================

// Module: text_msg_scheduler
// PURPOSE
//  Owns the text overlay: arbitrates two message requesters (req0 = game result, high priority;
//  req1 = status/turn, low priority) and drives textString/stringLength/xAddText/yAddText/enable
//  of the text generator. Updates land only on frame_start (no tearing); enforces a minimum
//  hold time per message and optional blinking.
// PARAMETERS
//  BITS_WIDTH      8   x coordinate width
//  BITS_HEIGHT     9   y coordinate width
//  MAX_TEXT_WIDTH  20  max characters; string bus = MAX_TEXT_WIDTH*8
//  HOLD_FRAMES     60  min frames a message is shown before req1 may replace it (>=1)
//  BLINK_FRAMES    30  frames per blink phase (>=1)
// PORTS
//  clock        in   1              system clock, all logic rising edge
//  resetn       in   1              asynchronous active-low reset
//  frame_start  in   1              1-cycle pulse at start of each LCD frame
//  clear        in   1              pulse: blank display at next frame_start
//  reqN         in   1              N=0,1: level request, held until ackN
//  reqN_string  in   MAX_TEXT_WIDTH*8 message, char 0 in bits [7:0]
//  reqN_len     in   6              character count
//  reqN_x       in   BITS_WIDTH     text x origin
//  reqN_y       in   BITS_HEIGHT    text y origin
//  reqN_blink   in   1              1 = blink message
//  ackN         out  1              1-cycle pulse: request captured
//  busy         out  1              1 while a capture awaits frame_start
//  textString   out  MAX_TEXT_WIDTH*8 to text generator
//  stringLength out  6              to text generator
//  xAddText     out  BITS_WIDTH     to text generator
//  yAddText     out  BITS_HEIGHT    to text generator
//  textEnable   out  1              to text generator enable
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, pending clear-flag 0.
//  States: IDLE (nothing shown), WAIT_FRAME (pending captured), SHOW.
//  Accept rule (IDLE or SHOW only): req0 wins if asserted. req1 accepted in IDLE, or in SHOW
//   when hold_cnt==0. req0 accepted in SHOW regardless of hold_cnt (preempts).
//  Capture cycle: latch string/len/x/y/blink of winner into pending regs; ackN=1 next cycle,
//   exactly one cycle; -> WAIT_FRAME, busy=1. No accepts in WAIT_FRAME.
//  WAIT_FRAME + frame_start: pending -> outputs same edge, hold_cnt=HOLD_FRAMES, blink_cnt=0,
//   textEnable=1 (0 if len==0), busy=0, -> SHOW. Outputs never change except on frame_start.
//  SHOW: each frame_start decrements hold_cnt (saturate 0). Message persists after expiry.
//  Blink: if blink, blink_cnt counts frame_starts; at BLINK_FRAMES wraps to 0 and textEnable
//   toggles. Non-blink: textEnable constant.
//  Length: len > MAX_TEXT_WIDTH clamped to MAX_TEXT_WIDTH on capture; len==0 acked, shown blank.
//  clear: sets clear-flag; at next frame_start in SHOW/IDLE: textEnable=0, stringLength=0,
//   -> IDLE. In WAIT_FRAME, the pending message is dropped too (-> IDLE, busy=0).
//   clear and accept in same cycle: clear wins, no capture, no ack.
//  frame_start in capture cycle: not applied to new message (takes next frame_start);
//   hold/blink counters of current message still update.
//  Reset mid-operation: immediate return to reset values; ack not issued for in-flight capture.
// TESTING
//  req1 "X TURN" len 6 in IDLE -> ack1 one cycle later; outputs unchanged until frame_start,
//   then stringLength=6, textEnable=1.
//  req1 again 10 frames later -> no ack until 60th frame_start; replaced on following frame.
//  req0 "X WINS" blink=1 during req1 hold -> ack0 immediately, shown next frame; textEnable
//   toggles every 30 frame_starts (off at 30, on at 60).
//  req0 and req1 same cycle in IDLE -> ack0 only; req1 acked after req0 hold (60 frames).
//  req1 len=40 -> stringLength=20; len=0 -> ack, textEnable stays 0.
//  clear with req1 same cycle -> no ack; next frame_start textEnable=0; resetn low in
//   WAIT_FRAME -> all outputs 0 at once, busy=0.

Source files
------------

// File: rtl/text_msg_scheduler.sv
// rtl/text_msg_scheduler.sv - text overlay message arbiter for the LCD text generator
// Two prioritised requesters; display updates land only on frame_start, with min-hold and blink.
module text_msg_scheduler #(
  parameter int BITS_WIDTH     = 8,
  parameter int BITS_HEIGHT    = 9,
  parameter int MAX_TEXT_WIDTH = 20,
  parameter int HOLD_FRAMES    = 60,
  parameter int BLINK_FRAMES   = 30
) (
  input  logic                        clock_i,
  input  logic                        resetn_i,
  input  logic                        frame_start_i,
  input  logic                        clear_i,
  input  logic                        req0_i,
  input  logic [MAX_TEXT_WIDTH*8-1:0] req0_string_i,
  input  logic [5:0]                  req0_len_i,
  input  logic [BITS_WIDTH-1:0]       req0_x_i,
  input  logic [BITS_HEIGHT-1:0]      req0_y_i,
  input  logic                        req0_blink_i,
  input  logic                        req1_i,
  input  logic [MAX_TEXT_WIDTH*8-1:0] req1_string_i,
  input  logic [5:0]                  req1_len_i,
  input  logic [BITS_WIDTH-1:0]       req1_x_i,
  input  logic [BITS_HEIGHT-1:0]      req1_y_i,
  input  logic                        req1_blink_i,
  output logic                        ack0_o,
  output logic                        ack1_o,
  output logic                        busy_o,
  output logic [MAX_TEXT_WIDTH*8-1:0] textString_o,
  output logic [5:0]                  stringLength_o,
  output logic [BITS_WIDTH-1:0]       xAddText_o,
  output logic [BITS_HEIGHT-1:0]      yAddText_o,
  output logic                        textEnable_o
);

  localparam int SW = MAX_TEXT_WIDTH * 8;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [5:0]    MAX_LEN    = 6'(MAX_TEXT_WIDTH);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SHOW} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   pend_string_q, pend_string_d;
  logic [5:0]      pend_len_q, pend_len_d;
  logic [BITS_WIDTH-1:0]  pend_x_q, pend_x_d;
  logic [BITS_HEIGHT-1:0] pend_y_q, pend_y_d;
  logic            pend_blink_q, pend_blink_d;
  logic [SW-1:0]   text_q, text_d;
  logic [5:0]      len_q, len_d;
  logic [BITS_WIDTH-1:0]  x_q, x_d;
  logic [BITS_HEIGHT-1:0] y_q, y_d;
  logic            en_q, en_d;
  logic            blink_q, blink_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            clr_q, clr_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;

  logic       clear_now, can_accept, take0, take1;
  logic [5:0] win_len;

  // A pending clear blocks new captures so it is applied before anything else is shown.
  assign clear_now  = clear_i | clr_q;
  assign can_accept = ((state_q == IDLE) || (state_q == SHOW)) && !clear_now;
  assign take0      = can_accept && req0_i;
  assign take1      = can_accept && !req0_i && req1_i && ((state_q == IDLE) || (hold_q == '0));
  assign win_len    = take0 ? req0_len_i : req1_len_i;

  always_comb begin
    state_d       = state_q;
    pend_string_d = pend_string_q;
    pend_len_d    = pend_len_q;
    pend_x_d      = pend_x_q;
    pend_y_d      = pend_y_q;
    pend_blink_d  = pend_blink_q;
    text_d        = text_q;
    len_d         = len_q;
    x_d           = x_q;
    y_d           = y_q;
    en_d          = en_q;
    blink_d       = blink_q;
    hold_d        = hold_q;
    blink_cnt_d   = blink_cnt_q;
    clr_d         = clr_q | clear_i;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;

    if (frame_start_i) begin
      if (clear_now) begin
        state_d     = IDLE;
        en_d        = 1'b0;
        len_d       = '0;
        hold_d      = '0;
        blink_cnt_d = '0;
        clr_d       = 1'b0;
      end else begin
        case (state_q)
          WAIT_FRAME: begin
            text_d      = pend_string_q;
            len_d       = pend_len_q;
            x_d         = pend_x_q;
            y_d         = pend_y_q;
            blink_d     = pend_blink_q;
            en_d        = (pend_len_q != '0);
            hold_d      = HOLD_INIT;
            blink_cnt_d = '0;
            state_d     = SHOW;
          end
          SHOW: begin
            if (hold_q != '0) hold_d = hold_q - HW'(1);
            if (blink_q) begin
              if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                en_d        = (len_q != '0) & ~en_q;
              end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Capture may share a cycle with frame_start; the new message waits for the next one.
    if (take0 || take1) begin
      pend_string_d = take0 ? req0_string_i : req1_string_i;
      pend_len_d    = (win_len > MAX_LEN) ? MAX_LEN : win_len;
      pend_x_d      = take0 ? req0_x_i : req1_x_i;
      pend_y_d      = take0 ? req0_y_i : req1_y_i;
      pend_blink_d  = take0 ? req0_blink_i : req1_blink_i;
      ack0_d        = take0;
      ack1_d        = take1;
      state_d       = WAIT_FRAME;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q       <= IDLE;
      pend_string_q <= '0;
      pend_len_q    <= '0;
      pend_x_q      <= '0;
      pend_y_q      <= '0;
      pend_blink_q  <= 1'b0;
      text_q        <= '0;
      len_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      en_q          <= 1'b0;
      blink_q       <= 1'b0;
      hold_q        <= '0;
      blink_cnt_q   <= '0;
      clr_q         <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_string_q <= pend_string_d;
      pend_len_q    <= pend_len_d;
      pend_x_q      <= pend_x_d;
      pend_y_q      <= pend_y_d;
      pend_blink_q  <= pend_blink_d;
      text_q        <= text_d;
      len_q         <= len_d;
      x_q           <= x_d;
      y_q           <= y_d;
      en_q          <= en_d;
      blink_q       <= blink_d;
      hold_q        <= hold_d;
      blink_cnt_q   <= blink_cnt_d;
      clr_q         <= clr_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
    end
  end

  assign ack0_o         = ack0_q;
  assign ack1_o         = ack1_q;
  assign busy_o         = (state_q == WAIT_FRAME);
  assign textString_o   = text_q;
  assign stringLength_o = len_q;
  assign xAddText_o     = x_q;
  assign yAddText_o     = y_q;
  assign textEnable_o   = en_q;

endmodule

// File: tb/tb_text_msg_scheduler.sv
// tb/tb_text_msg_scheduler.sv - directed self-checking bench for text_msg_scheduler
module tb_text_msg_scheduler;

  logic         clk = 1'b0;
  logic         resetn, frame_start, clear;
  logic         req0, req0_blink, req1, req1_blink;
  logic [159:0] req0_string, req1_string;
  logic [5:0]   req0_len, req1_len;
  logic [7:0]   req0_x, req1_x;
  logic [8:0]   req0_y, req1_y;
  logic         ack0, ack1, busy, text_en;
  logic [159:0] text_str;
  logic [5:0]   str_len;
  logic [7:0]   x_add;
  logic [8:0]   y_add;

  int vectors = 0;
  int miscompares = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int base;

  always #5 clk = ~clk;

  text_msg_scheduler dut (
    .clock_i(clk), .resetn_i(resetn), .frame_start_i(frame_start), .clear_i(clear),
    .req0_i(req0), .req0_string_i(req0_string), .req0_len_i(req0_len),
    .req0_x_i(req0_x), .req0_y_i(req0_y), .req0_blink_i(req0_blink),
    .req1_i(req1), .req1_string_i(req1_string), .req1_len_i(req1_len),
    .req1_x_i(req1_x), .req1_y_i(req1_y), .req1_blink_i(req1_blink),
    .ack0_o(ack0), .ack1_o(ack1), .busy_o(busy),
    .textString_o(text_str), .stringLength_o(str_len),
    .xAddText_o(x_add), .yAddText_o(y_add), .textEnable_o(text_en)
  );

  always @(negedge clk) begin
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
  end

  function automatic logic [159:0] make_str(input string s);
    logic [159:0] v;
    v = '0;
    for (int i = 0; i < s.len() && i < 20; i++) v[i*8 +: 8] = s[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (ack0) req0 = 1'b0;
    if (ack1) req1 = 1'b0;
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; frame_start = 1'b0; clear = 1'b0;
    req0 = 1'b0; req0_blink = 1'b0; req0_string = '0; req0_len = '0; req0_x = '0; req0_y = '0;
    req1 = 1'b0; req1_blink = 1'b0; req1_string = '0; req1_len = '0; req1_x = '0; req1_y = '0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    vectors++;
    if ({text_en, str_len, busy, ack0, ack1} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %0h want 0", {text_en, str_len, busy, ack0, ack1});
    end
    vectors++;
    if ({text_str, x_add, y_add} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got %0h want 0", {text_str, x_add, y_add});
    end
  endtask

  task automatic test_turn_and_hold();
    req1_string = make_str("X TURN"); req1_len = 6'd6; req1_x = 8'd40; req1_y = 9'd300;
    req1_blink = 1'b0; req1 = 1'b1;
    tick();
    vectors++;
    if ({ack1, busy, text_en, str_len} !== {1'b1, 1'b1, 1'b0, 6'd0}) begin
      miscompares++;
      $display("FAIL turn_ack got %0h want %0h", {ack1, busy, text_en, str_len}, {1'b1, 1'b1, 1'b0, 6'd0});
    end
    tick();
    vectors++;
    if (ack1 !== 1'b0) begin
      miscompares++;
      $display("FAIL turn_ack_pulse got %0b want 0", ack1);
    end
    do_frame();
    vectors++;
    if ({str_len, text_en, busy, x_add, y_add} !== {6'd6, 1'b1, 1'b0, 8'd40, 9'd300}) begin
      miscompares++;
      $display("FAIL turn_show got %0h want %0h", {str_len, text_en, busy, x_add, y_add},
               {6'd6, 1'b1, 1'b0, 8'd40, 9'd300});
    end
    vectors++;
    if (text_str !== make_str("X TURN")) begin
      miscompares++;
      $display("FAIL turn_string got %0h want %0h", text_str, make_str("X TURN"));
    end
    repeat (10) do_frame();
    req1_string = make_str("O TURN"); req1_x = 8'd50; req1 = 1'b1;
    base = ack1_cnt;
    repeat (49) do_frame();
    vectors++;
    if (ack1_cnt !== base) begin
      miscompares++;
      $display("FAIL hold_no_ack got %0d want %0d", ack1_cnt, base);
    end
    do_frame();
    vectors++;
    if (ack1_cnt !== base + 1) begin
      miscompares++;
      $display("FAIL hold_ack_at_60 got %0d want %0d", ack1_cnt, base + 1);
    end
    vectors++;
    if (text_str !== make_str("X TURN")) begin
      miscompares++;
      $display("FAIL hold_no_tear got %0h want %0h", text_str, make_str("X TURN"));
    end
    do_frame();
    vectors++;
    if ({text_str, x_add} !== {make_str("O TURN"), 8'd50}) begin
      miscompares++;
      $display("FAIL hold_replace got %0h want %0h", {text_str, x_add}, {make_str("O TURN"), 8'd50});
    end
  endtask

  task automatic test_preempt_blink();
    repeat (5) do_frame();
    req0_string = make_str("X WINS"); req0_len = 6'd6; req0_x = 8'd10; req0_y = 9'd20;
    req0_blink = 1'b1; req0 = 1'b1;
    tick();
    vectors++;
    if (ack0 !== 1'b1) begin
      miscompares++;
      $display("FAIL preempt_ack got %0b want 1", ack0);
    end
    do_frame();
    vectors++;
    if ({text_str, text_en} !== {make_str("X WINS"), 1'b1}) begin
      miscompares++;
      $display("FAIL preempt_show got %0h want %0h", {text_str, text_en}, {make_str("X WINS"), 1'b1});
    end
    repeat (29) do_frame();
    vectors++;
    if (text_en !== 1'b1) begin
      miscompares++;
      $display("FAIL blink_29 got %0b want 1", text_en);
    end
    do_frame();
    vectors++;
    if (text_en !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_30 got %0b want 0", text_en);
    end
    repeat (29) do_frame();
    vectors++;
    if (text_en !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_59 got %0b want 0", text_en);
    end
    do_frame();
    vectors++;
    if (text_en !== 1'b1) begin
      miscompares++;
      $display("FAIL blink_60 got %0b want 1", text_en);
    end
  endtask

  task automatic test_both_requests();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    do_frame();
    vectors++;
    if ({text_en, str_len} !== 7'd0) begin
      miscompares++;
      $display("FAIL clear_to_idle got %0h want 0", {text_en, str_len});
    end
    req0_string = make_str("GAME OVER"); req0_len = 6'd9; req0_blink = 1'b0; req0 = 1'b1;
    req1_string = make_str("P1 TURN"); req1_len = 6'd7; req1 = 1'b1;
    base = ack1_cnt;
    tick();
    vectors++;
    if ({ack0, ack1} !== 2'b10) begin
      miscompares++;
      $display("FAIL both_priority got %b want 10", {ack0, ack1});
    end
    do_frame();
    vectors++;
    if (text_str !== make_str("GAME OVER")) begin
      miscompares++;
      $display("FAIL both_show0 got %0h want %0h", text_str, make_str("GAME OVER"));
    end
    repeat (59) do_frame();
    vectors++;
    if (ack1_cnt !== base) begin
      miscompares++;
      $display("FAIL both_req1_wait got %0d want %0d", ack1_cnt, base);
    end
    do_frame();
    vectors++;
    if (ack1_cnt !== base + 1) begin
      miscompares++;
      $display("FAIL both_req1_ack got %0d want %0d", ack1_cnt, base + 1);
    end
    do_frame();
    vectors++;
    if (str_len !== 6'd7) begin
      miscompares++;
      $display("FAIL both_show1 got %0d want 7", str_len);
    end
  endtask

  task automatic test_length_and_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    do_frame();
    req1_string = make_str("LONG MESSAGE TWENTY!"); req1_len = 6'd40; req1 = 1'b1;
    tick();
    vectors++;
    if (ack1 !== 1'b1) begin
      miscompares++;
      $display("FAIL len40_ack got %0b want 1", ack1);
    end
    do_frame();
    vectors++;
    if ({str_len, text_en} !== {6'd20, 1'b1}) begin
      miscompares++;
      $display("FAIL len40_clamp got %0h want %0h", {str_len, text_en}, {6'd20, 1'b1});
    end
    repeat (60) do_frame();
    req1_string = make_str("HELLO"); req1_len = 6'd5; req1 = 1'b1; clear = 1'b1;
    base = ack1_cnt;
    tick();
    clear = 1'b0; req1 = 1'b0;
    tick();
    vectors++;
    if ({ack1_cnt, busy} !== {base, 1'b0}) begin
      miscompares++;
      $display("FAIL clear_beats_req got %0h want %0h", {ack1_cnt, busy}, {base, 1'b0});
    end
    do_frame();
    vectors++;
    if ({text_en, str_len} !== 7'd0) begin
      miscompares++;
      $display("FAIL clear_blank got %0h want 0", {text_en, str_len});
    end
    req1_string = make_str("EMPTY"); req1_len = 6'd0; req1 = 1'b1;
    tick();
    vectors++;
    if (ack1 !== 1'b1) begin
      miscompares++;
      $display("FAIL len0_ack got %0b want 1", ack1);
    end
    do_frame();
    vectors++;
    if ({text_en, str_len, busy} !== 8'd0) begin
      miscompares++;
      $display("FAIL len0_blank got %0h want 0", {text_en, str_len, busy});
    end
  endtask

  task automatic test_reset_mid();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    do_frame();
    req1_string = make_str("RESET"); req1_len = 6'd5; req1 = 1'b1;
    tick();
    vectors++;
    if ({ack1, busy, text_str} !== {1'b1, 1'b1, make_str("EMPTY")}) begin
      miscompares++;
      $display("FAIL mid_pending got %0h want %0h", {ack1, busy, text_str}, {1'b1, 1'b1, make_str("EMPTY")});
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if ({text_str, str_len, x_add, y_add, text_en, busy, ack0, ack1} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got %0h want 0", {text_str, str_len, x_add, y_add, text_en, busy, ack0, ack1});
    end
    req1 = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_turn_and_hold();
    test_preempt_blink();
    test_both_requests();
    test_length_and_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
